// File: rtl/multi_led_autocal_ctrl_pkg.sv
// Shared types and defaults for the multi-channel LED auto-calibration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multi_led_autocal_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DC_RAMP,
    ST_GAIN_STEP,
    ST_OBSERVE,
    ST_NEXT_CH,
    ST_RUN
  } state_e;

  localparam int DEF_SETTLE_CYC = 3;
  localparam int DEF_DC_TARGET  = 150;
  localparam int DEF_CLIP_LO    = 4;
  localparam int DEF_CLIP_HI    = 250;
  localparam int DEF_OBS_CYC    = 476;
  localparam int DEF_SLOT_CYC   = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // States in which the front end is owned by calibration.
  function automatic logic is_cal_state(input state_e s);
    return (s == ST_SETTLE) || (s == ST_DC_RAMP) || (s == ST_GAIN_STEP) ||
           (s == ST_OBSERVE) || (s == ST_NEXT_CH);
  endfunction

endpackage

// File: rtl/multi_led_autocal_ctrl_ch_setting_store.sv
// Per-channel (dc, gain) calibration result register file.
// Latency: write visible one cycle after we; read is combinational.
// Backpressure: none, a write is accepted every cycle.
// Ports: clk/rst_n (sync, active-low); we/wch/dc/gain write port;
//        rch read select, rd_dc/rd_gain read data.
module ch_setting_store #(
  parameter int NUM_CH = 2,
  parameter int DC_W   = 7,
  parameter int GAIN_W = 4,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [CH_W-1:0]   wch,
  input  logic [DC_W-1:0]   dc,
  input  logic [GAIN_W-1:0] gain,
  input  logic [CH_W-1:0]   rch,
  output logic [DC_W-1:0]   rd_dc,
  output logic [GAIN_W-1:0] rd_gain
);

  logic [DC_W-1:0]   dc_q   [NUM_CH];
  logic [DC_W-1:0]   dc_d   [NUM_CH];
  logic [GAIN_W-1:0] gain_q [NUM_CH];
  logic [GAIN_W-1:0] gain_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dc_d[i]   = dc_q[i];
      gain_d[i] = gain_q[i];
      if (we && (wch == CH_W'(i))) begin
        dc_d[i]   = dc;
        gain_d[i] = gain;
      end
    end
  end

  // Compare-based read keeps out-of-range selects (non power-of-two NUM_CH) at 0.
  always_comb begin
    rd_dc   = '0;
    rd_gain = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rch == CH_W'(i)) begin
        rd_dc   = dc_q[i];
        rd_gain = gain_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        dc_q[i]   <= '0;
        gain_q[i] <= '0;
      end else begin
        dc_q[i]   <= dc_d[i];
        gain_q[i] <= gain_d[i];
      end
    end
  end

endmodule

// File: rtl/multi_led_autocal_ctrl.sv
// NUM_CH LED front-end controller: per-channel DC/PGA auto-calibration, then round-robin sampling.
// Latency: all outputs registered; a run-mode sample appears one cycle after the last slot cycle.
// Backpressure: none; adc_data is consumed every cycle and sample_valid is a one-cycle strobe.
// Ports: clk/rst_n (sync, active-low); adc_data in; cal_start/run_en controls;
//        led_en/dc_comp/pga_gain front-end drive; sample_data/sample_ch/sample_valid out;
//        cal_busy/cal_done/cal_err status.
module multi_led_autocal_ctrl
  import multi_led_autocal_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DC_W       = 7,
  parameter int GAIN_W     = 4,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DC_TARGET  = DEF_DC_TARGET,
  parameter int CLIP_LO    = DEF_CLIP_LO,
  parameter int CLIP_HI    = DEF_CLIP_HI,
  parameter int OBS_CYC    = DEF_OBS_CYC,
  parameter int SLOT_CYC   = DEF_SLOT_CYC,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              cal_start,
  input  logic              run_en,
  output logic [NUM_CH-1:0] led_en,
  output logic [DC_W-1:0]   dc_comp,
  output logic [GAIN_W-1:0] pga_gain,
  output logic [ADC_W-1:0]  sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic              cal_busy,
  output logic              cal_done,
  output logic [NUM_CH-1:0] cal_err
);

  // One counter serves settle, observe and slot timing; they never overlap.
  localparam int CNT_MAX = max3(SETTLE_CYC, OBS_CYC, SLOT_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [DC_W-1:0]   DC_MAX   = '1;
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic [ADC_W-1:0]  sdat_q, sdat_d;
  logic [CH_W-1:0]   sch_q, sch_d;
  logic              svld_q, svld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;

  logic              st_we;
  logic [DC_W-1:0]   st_dc, rd_dc;
  logic [GAIN_W-1:0] st_gain, rd_gain;
  logic              below_target, clip;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (c == CH_W'(i));
    return r;
  endfunction

  // Read port follows ch_d so RUN settings change on the same edge as the channel.
  ch_setting_store #(
    .NUM_CH(NUM_CH), .DC_W(DC_W), .GAIN_W(GAIN_W), .CH_W(CH_W)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (st_we),
    .wch    (ch_q),
    .dc     (st_dc),
    .gain   (st_gain),
    .rch    (ch_d),
    .rd_dc  (rd_dc),
    .rd_gain(rd_gain)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    dc_d    = dc_q;
    gain_d  = gain_q;
    sdat_d  = sdat_q;
    sch_d   = sch_q;
    svld_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    st_we   = 1'b0;
    st_dc   = dc_q;
    st_gain = gain_q;
    led_d   = '0;
    busy_d  = 1'b0;

    below_target = adc_data < ADC_W'(DC_TARGET);
    clip         = (adc_data < ADC_W'(CLIP_LO)) || (adc_data > ADC_W'(CLIP_HI));

    case (state_q)
      ST_IDLE: begin
        if (cal_start) begin
          done_d  = 1'b0;
          err_d   = '0;
          ch_d    = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (run_en && done_q) begin
          ch_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_DC_RAMP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DC_RAMP: begin
        if (below_target) begin
          state_d = ST_GAIN_STEP;
        end else if (dc_q == DC_MAX) begin
          err_d   = err_q | onehot(ch_q);
          st_we   = 1'b1;
          st_dc   = DC_MAX;
          st_gain = '0;
          state_d = ST_NEXT_CH;
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end
      ST_GAIN_STEP: begin
        if (gain_q == GAIN_MAX) begin
          st_we   = 1'b1;
          st_gain = GAIN_MAX;
          state_d = ST_NEXT_CH;
        end else begin
          gain_d  = gain_q + GAIN_W'(1);
          cnt_d   = '0;
          state_d = ST_OBSERVE;
        end
      end
      ST_OBSERVE: begin
        if (clip) begin
          // Current gain clipped; keep the previous, clip-free one (gain_q >= 1 here).
          st_we   = 1'b1;
          st_gain = gain_q - GAIN_W'(1);
          state_d = ST_NEXT_CH;
        end else if (cnt_q == CNT_W'(OBS_CYC - 1)) begin
          state_d = ST_GAIN_STEP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT_CH: begin
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (!run_en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(SLOT_CYC - 1)) begin
          sdat_d = adc_data;
          sch_d  = ch_q;
          svld_d = 1'b1;
          cnt_d  = '0;
          ch_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered front-end drive reflects the state being entered.
    busy_d = is_cal_state(state_d);
    case (state_d)
      ST_SETTLE: begin
        led_d  = onehot(ch_d);
        dc_d   = '0;
        gain_d = '0;
      end
      ST_DC_RAMP, ST_GAIN_STEP, ST_OBSERVE: led_d = onehot(ch_d);
      ST_RUN: begin
        led_d  = onehot(ch_d);
        dc_d   = rd_dc;
        gain_d = rd_gain;
      end
      default: begin
        dc_d   = '0;
        gain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      dc_q    <= '0;
      gain_q  <= '0;
      led_q   <= '0;
      sdat_q  <= '0;
      sch_q   <= '0;
      svld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      dc_q    <= dc_d;
      gain_q  <= gain_d;
      led_q   <= led_d;
      sdat_q  <= sdat_d;
      sch_q   <= sch_d;
      svld_q  <= svld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign led_en       = led_q;
  assign dc_comp      = dc_q;
  assign pga_gain     = gain_q;
  assign sample_data  = sdat_q;
  assign sample_ch    = sch_q;
  assign sample_valid = svld_q;
  assign cal_busy     = busy_q;
  assign cal_done     = done_q;
  assign cal_err      = err_q;

endmodule

// File: tb/tb_multi_led_autocal_ctrl.sv
// Directed bench for multi_led_autocal_ctrl with default parameters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_multi_led_autocal_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_data = '0;
  logic       cal_start = 1'b0;
  logic       run_en = 1'b0;
  logic [1:0] led_en;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic [7:0] sample_data;
  logic [0:0] sample_ch;
  logic       sample_valid;
  logic       cal_busy;
  logic       cal_done;
  logic [1:0] cal_err;

  int n_assert = 0;
  int n_fail   = 0;
  bit react    = 1'b0;
  // Per-channel ADC profile: ramp value while dc_comp < thr, then mid, 255 once pga_gain >= clipg.
  int thr[2], hi[2], mid[2], clipg[2];

  int cyc, mdc, mg, t2, t3;
  bit led_ok;

  multi_led_autocal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .cal_start(cal_start), .run_en(run_en),
    .led_en(led_en), .dc_comp(dc_comp), .pga_gain(pga_gain), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_valid(sample_valid), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_err(cal_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_prof(input int ch, input int t, input int h, input int m, input int g);
    thr[ch] = t; hi[ch] = h; mid[ch] = m; clipg[ch] = g;
  endtask

  task automatic step();
    int c;
    @(posedge clk);
    #1;
    if (react) begin
      c = int'(led_en[1]);
      if (int'(dc_comp) < thr[c])          adc_data = 8'(hi[c]);
      else if (int'(pga_gain) >= clipg[c]) adc_data = 8'd255;
      else                                 adc_data = 8'(mid[c]);
    end
  endtask

  function automatic logic [7:0] val(input int j, input int seed);
    return 8'((j * 37 + seed) % 256);
  endfunction

  // Steps until the channel leaves (led_en drops to 0, i.e. NEXT_CH), tracking its trajectory.
  task automatic cal_until_next(input string tag, input int budget, output int n, output int max_dc,
                                output int max_g, output int tg2, output int tg3, output bit ok);
    logic [1:0] led0;
    bit hit;
    led0 = led_en; n = 0; max_dc = 0; max_g = 0; tg2 = -1; tg3 = -1; ok = 1'b1; hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      n++;
      if (led_en == 2'b00) begin
        hit = 1'b1;
        break;
      end
      if (led_en != led0) ok = 1'b0;
      if (int'(dc_comp) > max_dc) max_dc = int'(dc_comp);
      if (int'(pga_gain) > max_g) max_g = int'(pga_gain);
      if (pga_gain == 4'd2 && tg2 < 0) tg2 = n;
      if (pga_gain == 4'd3 && tg3 < 0) tg3 = n;
    end
    chk({tag, "_reached_next_ch"}, 32'(hit), 1);
  endtask

  task automatic run_check(input int n, input int dc0, input int g0, input int dc1, input int g1,
                           input int seed);
    int slot, odd, lastj;
    bit vexp;
    react = 1'b0;
    run_en = 1'b1;
    for (int j = 0; j < n; j++) begin
      step();
      slot = j / 5;
      odd  = slot % 2;
      chk("run_led", 32'(led_en), (odd != 0) ? 2 : 1);
      chk("run_dc", 32'(dc_comp), (odd != 0) ? dc1 : dc0);
      chk("run_gain", 32'(pga_gain), (odd != 0) ? g1 : g0);
      chk("run_busy", 32'(cal_busy), 0);
      vexp = (j >= 5) && (j % 5 == 0);
      chk("run_valid", 32'(sample_valid), 32'(vexp));
      if (vexp) begin
        chk("run_sample_ch", 32'(sample_ch), (slot - 1) % 2);
        chk("run_sample_data", 32'(sample_data), 32'(val(j - 1, seed)));
      end
      adc_data  = val(j, seed);
      cal_start = (j == 7);
    end
    run_en = 1'b0;
    cal_start = 1'b0;
    step();
    chk("run_exit_led", 32'(led_en), 0);
    chk("run_exit_dc", 32'(dc_comp), 0);
    chk("run_exit_gain", 32'(pga_gain), 0);
    for (int k = 0; k < 6; k++) begin
      chk("run_exit_no_strobe", 32'(sample_valid), 0);
      step();
    end
    lastj = ((n - 1) / 5) * 5;
    chk("run_exit_sample_hold", 32'(sample_data), 32'(val(lastj - 1, seed)));
    chk("run_exit_done", 32'(cal_done), 1);
  endtask

  initial begin
    // Reset with arbitrary inputs
    rst_n = 1'b0; cal_start = 1'b1; run_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adc_data = 8'($urandom);
      step();
    end
    chk("rst_led", 32'(led_en), 0);
    chk("rst_dc", 32'(dc_comp), 0);
    chk("rst_gain", 32'(pga_gain), 0);
    chk("rst_sdat", 32'(sample_data), 0);
    chk("rst_sch", 32'(sample_ch), 0);
    chk("rst_svld", 32'(sample_valid), 0);
    chk("rst_busy", 32'(cal_busy), 0);
    chk("rst_done", 32'(cal_done), 0);
    chk("rst_err", 32'(cal_err), 0);

    // run_en without a completed calibration stays idle
    rst_n = 1'b1; cal_start = 1'b0; run_en = 1'b1;
    step(); step();
    chk("idle_norun_led", 32'(led_en), 0);
    chk("idle_norun_busy", 32'(cal_busy), 0);
    run_en = 1'b0;

    // Cal A: ch0 -> (30,4) via clip at gain 5; ch1 -> (40,7) via clip at gain 8
    set_prof(0, 30, 200, 100, 5);
    set_prof(1, 40, 200, 100, 8);
    react = 1'b1;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    chk("calA_start_led", 32'(led_en), 1);
    chk("calA_start_busy", 32'(cal_busy), 1);
    chk("calA_start_dc", 32'(dc_comp), 0);
    cal_until_next("calA_ch0", 3000, cyc, mdc, mg, t2, t3, led_ok);
    chk("calA_ch0_cycles", 32'(cyc), 1944);
    chk("calA_ch0_max_dc", 32'(mdc), 30);
    chk("calA_ch0_max_gain", 32'(mg), 5);
    chk("calA_ch0_gain2_at", 32'(t2), 512);
    chk("calA_ch0_led_steady", 32'(led_ok), 1);
    chk("calA_next_dc", 32'(dc_comp), 0);
    chk("calA_next_gain", 32'(pga_gain), 0);
    chk("calA_next_busy", 32'(cal_busy), 1);
    step();
    chk("calA_ch1_led", 32'(led_en), 2);
    chk("calA_ch1_dc", 32'(dc_comp), 0);
    cal_until_next("calA_ch1", 4000, cyc, mdc, mg, t2, t3, led_ok);
    chk("calA_ch1_cycles", 32'(cyc), 3385);
    chk("calA_ch1_max_dc", 32'(mdc), 40);
    chk("calA_ch1_max_gain", 32'(mg), 8);
    chk("calA_ch1_done_early", 32'(cal_done), 0);
    step();
    chk("calA_done", 32'(cal_done), 1);
    chk("calA_err", 32'(cal_err), 0);
    chk("calA_idle_busy", 32'(cal_busy), 0);
    chk("calA_idle_led", 32'(led_en), 0);

    run_check(23, 30, 4, 40, 7, 11);

    // Cal B: cal_start wins over run_en; ch0 never clips, ch1 saturates the DC ramp
    set_prof(0, 20, 200, 120, 16);
    set_prof(1, 255, 255, 255, 16);
    react = 1'b1;
    cal_start = 1'b1; run_en = 1'b1;
    step();
    cal_start = 1'b0; run_en = 1'b0;
    chk("calB_prio_busy", 32'(cal_busy), 1);
    chk("calB_prio_dc", 32'(dc_comp), 0);
    chk("calB_prio_led", 32'(led_en), 1);
    chk("calB_done_cleared", 32'(cal_done), 0);
    cal_until_next("calB_ch0", 8000, cyc, mdc, mg, t2, t3, led_ok);
    chk("calB_ch0_cycles", 32'(cyc), 7180);
    chk("calB_ch0_max_gain", 32'(mg), 15);
    chk("calB_ch0_max_dc", 32'(mdc), 20);
    chk("calB_ch0_gain2_at", 32'(t2), 502);
    chk("calB_ch0_gain_period", 32'(t3 - t2), 477);
    chk("calB_ch0_err", 32'(cal_err), 0);
    step();
    chk("calB_ch1_led", 32'(led_en), 2);
    cal_until_next("calB_ch1", 500, cyc, mdc, mg, t2, t3, led_ok);
    chk("calB_ch1_cycles", 32'(cyc), 131);
    chk("calB_ch1_max_dc", 32'(mdc), 127);
    chk("calB_ch1_max_gain", 32'(mg), 0);
    chk("calB_ch1_err", 32'(cal_err), 2);
    step();
    chk("calB_done", 32'(cal_done), 1);
    chk("calB_err_sticky", 32'(cal_err), 2);
    chk("calB_idle_busy", 32'(cal_busy), 0);

    run_check(13, 20, 15, 127, 0, 5);

    // Cal C: quick ch0, then reset while ch1 is observing
    set_prof(0, 0, 0, 100, 1);
    set_prof(1, 0, 0, 100, 16);
    react = 1'b1;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    chk("calC_err_cleared", 32'(cal_err), 0);
    chk("calC_done_cleared", 32'(cal_done), 0);
    cal_until_next("calC_ch0", 100, cyc, mdc, mg, t2, t3, led_ok);
    chk("calC_ch0_cycles", 32'(cyc), 6);
    step();
    chk("calC_ch1_led", 32'(led_en), 2);
    for (int k = 0; k < 10; k++) step();
    chk("calC_obs_gain", 32'(pga_gain), 1);
    chk("calC_obs_busy", 32'(cal_busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_led", 32'(led_en), 0);
    chk("midrst_gain", 32'(pga_gain), 0);
    chk("midrst_busy", 32'(cal_busy), 0);
    chk("midrst_done", 32'(cal_done), 0);
    chk("midrst_err", 32'(cal_err), 0);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    chk("restart_led_ch0", 32'(led_en), 1);
    chk("restart_busy", 32'(cal_busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
